// File: rtl/dff_input_debounce.sv
// dff_input_debounce: synchronizer plus stability-qualified debounce FSM.
// Edge pulses (rise/fall) are built only with DFF_INPUT_DEBOUNCE_EDGE_EN.
module dff_input_debounce #(
   parameter int SYNC_STAGES   = 2,
   parameter int CNT_WIDTH     = 8,
   parameter int STABLE_CYCLES = 16
) (
   input  logic clk,
   input  logic clear_n,
   input  logic din,
   output logic dout,
   output logic dout_bar,
   output logic rise,
   output logic fall,
   output logic stable
);

   typedef enum logic [1:0] {
      IDLE_LOW,
      CHECK_HIGH,
      IDLE_HIGH,
      CHECK_LOW
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST =
      CNT_WIDTH'(STABLE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   s;

   state_t                 state_q;
   state_t                 state_d;
   logic [CNT_WIDTH-1:0]   cnt_q;
   logic [CNT_WIDTH-1:0]   cnt_d;
   logic                   dout_q;
   logic                   dout_d;
   logic                   dout_bar_q;
   logic                   dout_bar_d;
   logic                   stable_q;
   logic                   stable_d;

   // Plain shift chain: nothing between stages so each flop can resolve.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], din};
   end

   assign s = sync_q[SYNC_STAGES-1];

   // Synchronizer flops, cleared to 0 so the FSM starts from a known low.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   // Next-state logic: a level change is accepted after STABLE_CYCLES
   // consecutive matching samples; any mismatch falls back to idle.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      dout_d     = dout_q;
      dout_bar_d = dout_bar_q;
      unique case (state_q)
         IDLE_LOW: begin
            if (s) begin
               state_d = CHECK_HIGH;
               cnt_d   = CNT_ONE;
            end
         end
         CHECK_HIGH: begin
            if (!s) begin
               state_d = IDLE_LOW;
               cnt_d   = CNT_ZERO;
            end else if (cnt_q == CNT_LAST) begin
               state_d    = IDLE_HIGH;
               cnt_d      = CNT_ZERO;
               dout_d     = 1'b1;
               dout_bar_d = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         IDLE_HIGH: begin
            if (!s) begin
               state_d = CHECK_LOW;
               cnt_d   = CNT_ONE;
            end
         end
         CHECK_LOW: begin
            if (s) begin
               state_d = IDLE_HIGH;
               cnt_d   = CNT_ZERO;
            end else if (cnt_q == CNT_LAST) begin
               state_d    = IDLE_LOW;
               cnt_d      = CNT_ZERO;
               dout_d     = 1'b0;
               dout_bar_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
      endcase
      stable_d = (state_d == IDLE_LOW) || (state_d == IDLE_HIGH);
   end

   // FSM state, counter and registered level outputs.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state_q    <= IDLE_LOW;
         cnt_q      <= CNT_ZERO;
         dout_q     <= 1'b0;
         dout_bar_q <= 1'b1;
         stable_q   <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dout_q     <= dout_d;
         dout_bar_q <= dout_bar_d;
         stable_q   <= stable_d;
      end
   end

   assign dout     = dout_q;
   assign dout_bar = dout_bar_q;
   assign stable   = stable_q;

`ifdef DFF_INPUT_DEBOUNCE_EDGE_EN
   logic rise_q;
   logic rise_d;
   logic fall_q;
   logic fall_d;

   // dout only moves on acceptance, so its transition marks the edge.
   always_comb begin
      rise_d = dout_d & ~dout_q;
      fall_d = ~dout_d & dout_q;
   end

   // One-cycle edge pulses aligned with the first cycle of the new level.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign rise = rise_q;
   assign fall = fall_q;
`else
   assign rise = 1'b0;
   assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_dff_input_debounce.sv
// tb_dff_input_debounce: directed scoreboard bench, SYNC=2, STABLE=4.
// Expected per-edge outputs are queued then popped after each edge.
module tb_dff_input_debounce;

   logic clk;
   logic clear_n;
   logic din;
   logic dout;
   logic dout_bar;
   logic rise;
   logic fall;
   logic stable;

`ifdef DFF_INPUT_DEBOUNCE_EDGE_EN
   localparam logic EDGE = 1'b1;
`else
   localparam logic EDGE = 1'b0;
`endif

   typedef struct {
      string      tag;
      logic [4:0] v;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   dff_input_debounce #(
      .SYNC_STAGES   (2),
      .CNT_WIDTH     (8),
      .STABLE_CYCLES (4)
   ) dut (
      .clk      (clk),
      .clear_n  (clear_n),
      .din      (din),
      .dout     (dout),
      .dout_bar (dout_bar),
      .rise     (rise),
      .fall     (fall),
      .stable   (stable)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Queue one expected output vector {dout,dout_bar,rise,fall,stable}.
   task automatic push(input string tag, input logic d,
                       input logic r, input logic f, input logic st);
      exp_t e;
      e.tag = tag;
      e.v   = {d, ~d, r & EDGE, f & EDGE, st};
      sb.push_back(e);
   endtask

   task automatic check_now();
      exp_t       e;
      logic [4:0] obs;
      obs = {dout, dout_bar, rise, fall, stable};
      n_assert++;
      if (sb.size() == 0) begin
         n_fail++;
         $error("FAIL sb_empty: observed %b required a queued entry",
                obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.v) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", e.tag, obs, e.v);
         end
      end
   endtask

   // Advance one edge and compare away from it.
   task automatic tick();
      @(posedge clk);
      #1;
      check_now();
   endtask

   initial begin
      clear_n = 1'b1;
      din     = 1'b1;
      #2;
      // async reset with din high, before any clock edge
      clear_n = 1'b0;
      #1;
      push("reset", 1'b0, 1'b0, 1'b0, 1'b1);
      check_now();

      din = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      clear_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         push("idle_low", 1'b0, 1'b0, 1'b0, 1'b1);
         tick();
      end

      // glitch: din high for 3 cycles
      din = 1'b1;
      push("glitch_e1", 1'b0, 1'b0, 1'b0, 1'b1);
      push("glitch_e2", 1'b0, 1'b0, 1'b0, 1'b1);
      push("glitch_e3", 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      tick();
      din = 1'b0;
      push("glitch_e4", 1'b0, 1'b0, 1'b0, 1'b0);
      push("glitch_e5", 1'b0, 1'b0, 1'b0, 1'b0);
      push("glitch_e6", 1'b0, 1'b0, 1'b0, 1'b1);
      push("glitch_e7", 1'b0, 1'b0, 1'b0, 1'b1);
      push("glitch_e8", 1'b0, 1'b0, 1'b0, 1'b1);
      repeat (5) tick();

      // clean rise
      din = 1'b1;
      push("rise_e1", 1'b0, 1'b0, 1'b0, 1'b1);
      push("rise_e2", 1'b0, 1'b0, 1'b0, 1'b1);
      push("rise_e3", 1'b0, 1'b0, 1'b0, 1'b0);
      push("rise_e4", 1'b0, 1'b0, 1'b0, 1'b0);
      push("rise_e5", 1'b0, 1'b0, 1'b0, 1'b0);
      push("rise_e6", 1'b1, 1'b1, 1'b0, 1'b1);
      push("rise_e7", 1'b1, 1'b0, 1'b0, 1'b1);
      push("rise_e8", 1'b1, 1'b0, 1'b0, 1'b1);
      repeat (8) tick();

      // clean fall
      din = 1'b0;
      push("fall_e1", 1'b1, 1'b0, 1'b0, 1'b1);
      push("fall_e2", 1'b1, 1'b0, 1'b0, 1'b1);
      push("fall_e3", 1'b1, 1'b0, 1'b0, 1'b0);
      push("fall_e4", 1'b1, 1'b0, 1'b0, 1'b0);
      push("fall_e5", 1'b1, 1'b0, 1'b0, 1'b0);
      push("fall_e6", 1'b0, 1'b0, 1'b1, 1'b1);
      push("fall_e7", 1'b0, 1'b0, 1'b0, 1'b1);
      push("fall_e8", 1'b0, 1'b0, 1'b0, 1'b1);
      repeat (8) tick();

      // reset while CHECK_HIGH with cnt=2
      din = 1'b1;
      push("mid_e1", 1'b0, 1'b0, 1'b0, 1'b1);
      push("mid_e2", 1'b0, 1'b0, 1'b0, 1'b1);
      push("mid_e3", 1'b0, 1'b0, 1'b0, 1'b0);
      push("mid_e4", 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (4) tick();
      clear_n = 1'b0;
      #1;
      push("mid_reset", 1'b0, 1'b0, 1'b0, 1'b1);
      check_now();
      #1;
      clear_n = 1'b1;
      push("req_e1", 1'b0, 1'b0, 1'b0, 1'b1);
      push("req_e2", 1'b0, 1'b0, 1'b0, 1'b1);
      push("req_e3", 1'b0, 1'b0, 1'b0, 1'b0);
      push("req_e4", 1'b0, 1'b0, 1'b0, 1'b0);
      push("req_e5", 1'b0, 1'b0, 1'b0, 1'b0);
      push("req_e6", 1'b1, 1'b1, 1'b0, 1'b1);
      push("req_e7", 1'b1, 1'b0, 1'b0, 1'b1);
      repeat (7) tick();

      n_assert++;
      assert (sb.size() == 0) else begin
         n_fail++;
         $error("FAIL sb_drain: observed %0d entries expected 0",
                sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
